// File: rtl/ps2_keyboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_pkg
// Purpose  : Shared types, scancode constants and helpers for the PS/2
//            Set-2 keyboard event assembler.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_keyboard_pkg;

    typedef logic [7:0] byte_t;

    typedef struct packed {
        logic  brk;
        logic  ext;
        byte_t code;
    } key_event_t;

    localparam byte_t SC_EXT        = 8'hE0;
    localparam byte_t SC_BREAK      = 8'hF0;
    localparam byte_t SC_PAUSE      = 8'hE1;
    localparam byte_t SC_BAT_OK     = 8'hAA;
    localparam byte_t SC_ACK        = 8'hFA;
    localparam byte_t SC_RESEND     = 8'hFE;
    localparam byte_t SC_ECHO       = 8'hEE;
    localparam byte_t SC_ERR0       = 8'h00;
    localparam byte_t SC_ERR1       = 8'hFF;
    localparam byte_t SC_FAKE_SHIFT = 8'h12;
    localparam byte_t SC_PAUSE_KEY  = 8'h77;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } kbd_state_t;

    // Controller/housekeeping bytes that never form part of a key sequence.
    function automatic logic is_control(input byte_t b);
        return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_RESEND) ||
               (b == SC_ECHO)   || (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

    // One-hot {gui, alt, ctrl, shift} mask for a modifier key, zero otherwise.
    function automatic logic [3:0] modifier_mask(input logic ext, input byte_t code);
        logic [3:0] m;
        m = 4'b0000;
        if (!ext) begin
            if (code == 8'h12 || code == 8'h59) m = 4'b0001;
            else if (code == 8'h14)             m = 4'b0010;
            else if (code == 8'h11)             m = 4'b0100;
        end else begin
            if (code == 8'h14)                      m = 4'b0010;
            else if (code == 8'h11)                 m = 4'b0100;
            else if (code == 8'h1F || code == 8'h27) m = 4'b1000;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_keyboard_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kbd_fifo
// Purpose  : Show-ahead event FIFO with registered write; a push on full is
//            accepted only when a pop frees the head slot in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard
// Purpose  : Folds PS/2 Set-2 E0/F0/E1 byte sequences into key events and
//            queues them for a valid/ready reader. Define KBD_MODIFIERS_EN
//            to track shift/ctrl/alt/gui state on modifiers_o.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic [9:0] key_o,
    output logic       key_valid_o,
    input  logic       key_ready_i,
    output logic       overflow_o,
    output logic [3:0] modifiers_o
);

    kbd_state_t state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       overflow_q, overflow_d;
    logic       push;
    key_event_t ev;
    logic       fifo_full;
    logic       fifo_empty;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        push    = 1'b0;
        ev      = '0;
        if (valid_i) begin
            case (state_q)
                ST_IDLE, ST_EXT: begin
                    if (is_control(data_i)) begin
                        state_d = ST_IDLE;
                    end else if (data_i == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (data_i == SC_BREAK) begin
                        state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
                    end else if (data_i == SC_PAUSE) begin
                        state_d = ST_PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end else begin
                        state_d = ST_IDLE;
                        // E0 12 is the synthetic shift some keys wrap themselves in
                        if (!(state_q == ST_EXT && data_i == SC_FAKE_SHIFT)) begin
                            push    = 1'b1;
                            ev.ext  = (state_q == ST_EXT);
                            ev.code = data_i;
                        end
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    if (!is_control(data_i) &&
                        !(state_q == ST_EXT_BRK && data_i == SC_FAKE_SHIFT)) begin
                        push    = 1'b1;
                        ev.brk  = 1'b1;
                        ev.ext  = (state_q == ST_EXT_BRK);
                        ev.code = data_i;
                    end
                end
                ST_PAUSE: begin
                    if (is_control(data_i)) begin
                        state_d = ST_IDLE;
                        skip_d  = 3'd0;
                    end else if (skip_q == 3'd1) begin
                        state_d = ST_IDLE;
                        skip_d  = 3'd0;
                        push    = 1'b1;
                        ev.ext  = 1'b1;
                        ev.code = SC_PAUSE_KEY;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    skip_d  = 3'd0;
                end
            endcase
        end
        // A full FIFO is full, hence non-empty, so key_ready_i alone means a pop
        overflow_d = overflow_q | (push && fifo_full && !key_ready_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            skip_q     <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            overflow_q <= overflow_d;
        end
    end

    kbd_fifo #(
        .WIDTH($bits(key_event_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push),
        .push_data_i (ev),
        .full_o      (fifo_full),
        .pop_i       (key_ready_i),
        .pop_data_o  (key_o),
        .empty_o     (fifo_empty)
    );

    assign key_valid_o = !fifo_empty;
    assign overflow_o  = overflow_q;

`ifdef KBD_MODIFIERS_EN
    logic [3:0] modifiers_q, modifiers_d;

    always_comb begin
        modifiers_d = modifiers_q;
        if (push) begin
            if (ev.brk) modifiers_d = modifiers_q & ~modifier_mask(ev.ext, ev.code);
            else        modifiers_d = modifiers_q |  modifier_mask(ev.ext, ev.code);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) modifiers_q <= 4'b0000;
        else         modifiers_q <= modifiers_d;
    end

    assign modifiers_o = modifiers_q;
`else
    assign modifiers_o = 4'b0000;
`endif

endmodule
`default_nettype wire
